// File: rtl/mem_arbiter_pkg.sv
// Shared types for the SRAM arbiter: sequencer states and port ids.
// Also the helper that widens a word address onto the SRAM pins.
package mem_arbiter_pkg;

  localparam int AW  = 16;
  localparam int RAW = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR1,
    S_WR2,
    S_WR3
  } state_t;

  typedef enum logic {
    P_IF,
    P_DATA
  } port_t;

  function automatic logic [RAW-1:0] sram_addr(
    input logic [AW-1:0] a
  );
    return {2'b00, a};
  endfunction

endpackage

// File: rtl/mem_arbiter_sram_timing.sv
// SRAM access sequencer: one-cycle read, setup/pulse/hold write.
// All pins are registered from the next state, so none are combinational.
module mem_arbiter_sram_timing
  import mem_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_write,
  input  logic [AW-1:0]  addr,
  input  logic [15:0]    wdata,
  output logic           busy,
  output logic           done,
  output logic [15:0]    rdata,
  output logic [RAW-1:0] ram_addr,
  output logic [15:0]    ram_dout,
  input  logic [15:0]    ram_din,
  output logic           ram_data_oe,
  output logic           ram_en_n,
  output logic           ram_oe_n,
  output logic           ram_we_n
);

  state_t state, state_nx;
  logic   en_nx, oe_nx, we_nx, doe_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = is_write ? S_WR1 : S_RD;
        end
      end
      S_RD:    state_nx = S_IDLE;
      S_WR1:   state_nx = S_WR2;
      S_WR2:   state_nx = S_WR3;
      S_WR3:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    en_nx  = 1'b1;
    oe_nx  = 1'b1;
    we_nx  = 1'b1;
    doe_nx = 1'b0;
    unique case (state_nx)
      S_RD: begin
        en_nx = 1'b0;
        oe_nx = 1'b0;
      end
      S_WR1, S_WR3: begin
        en_nx  = 1'b0;
        doe_nx = 1'b1;
      end
      S_WR2: begin
        en_nx  = 1'b0;
        we_nx  = 1'b0;
        doe_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      ram_en_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_data_oe <= 1'b0;
      ram_addr    <= '0;
      ram_dout    <= '0;
    end else begin
      state       <= state_nx;
      ram_en_n    <= en_nx;
      ram_oe_n    <= oe_nx;
      ram_we_n    <= we_nx;
      ram_data_oe <= doe_nx;
      if (start && state == S_IDLE) begin
        ram_addr <= sram_addr(addr);
        ram_dout <= wdata;
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_RD) || (state == S_WR3);
  assign rdata = ram_din;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM between fetch and data ports; data port wins ties.
// Produces per-port ready pulses, held read data and the fetch stall.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [AW-1:0]  if_addr,
  output logic [15:0]    if_rdata,
  output logic           if_ready,
  output logic           if_stall,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [AW-1:0]  mem_addr,
  input  logic [15:0]    mem_wdata,
  output logic [15:0]    mem_rdata,
  output logic           mem_ready,
  output logic [RAW-1:0] ram_addr,
  output logic [15:0]    ram_dout,
  input  logic [15:0]    ram_din,
  output logic           ram_data_oe,
  output logic           ram_en_n,
  output logic           ram_oe_n,
  output logic           ram_we_n
);

  logic          busy, done, start, sel_wr, gnt_wr;
  logic          if_elig, mem_elig;
  port_t         sel, gnt_port;
  logic [AW-1:0] sel_addr;
  logic [15:0]   rdata;

  // A port is ignored in its own ready cycle.
  assign if_elig  = if_req & ~if_ready;
  assign mem_elig = (mem_read | mem_write) & ~mem_ready;

  always_comb begin
    start  = 1'b0;
    sel    = P_IF;
    sel_wr = 1'b0;
    if (!busy) begin
      unique case (1'b1)
        mem_elig: begin
          start  = 1'b1;
          sel    = P_DATA;
          sel_wr = mem_write;
        end
        if_elig & ~mem_elig: begin
          start = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sel_addr = (sel == P_DATA) ? mem_addr : if_addr;

  mem_arbiter_sram_timing u_tim (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_write    (sel_wr),
    .addr        (sel_addr),
    .wdata       (mem_wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .ram_din     (ram_din),
    .ram_data_oe (ram_data_oe),
    .ram_en_n    (ram_en_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_port  <= P_IF;
      gnt_wr    <= 1'b0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if (start) begin
        gnt_port <= sel;
        gnt_wr   <= sel_wr;
      end
      if_ready  <= done && gnt_port == P_IF;
      mem_ready <= done && gnt_port == P_DATA;
      if (done && gnt_port == P_IF) begin
        if_rdata <= rdata;
      end
      if (done && gnt_port == P_DATA && !gnt_wr) begin
        mem_rdata <= rdata;
      end
    end
  end

  assign if_stall = if_req & ~if_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM pin model, transaction-level reference
// model checked every cycle, plus directed scenarios with literal values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ready, if_stall;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout, ram_din;
  logic        ram_data_oe, ram_en_n, ram_oe_n, ram_we_n;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .if_stall    (if_stall),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .ram_din     (ram_din),
    .ram_data_oe (ram_data_oe),
    .ram_en_n    (ram_en_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n)
  );

  // Board SRAM: reads while enabled, latches data when we_n is low.
  logic [15:0] sram [0:65535];
  logic [15:0] refm [0:65535];

  assign ram_din = (!ram_en_n && !ram_oe_n) ?
                   sram[ram_addr[15:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!ram_en_n && !ram_we_n) begin
      sram[ram_addr[15:0]] <= ram_dout;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: an access occupies ph=1..len cycles after its
  // grant; ready is seen the cycle after the last one.
  bit          live = 1'b0;
  int          ph = 0;
  int          len = 0;
  bit          mport = 1'b0;
  bit          mwr = 1'b0;
  logic [15:0] maddr = '0;
  logic [15:0] mwd = '0;
  logic        e_ifr = 1'b0;
  logic        e_mr = 1'b0;
  logic [15:0] e_ifd = '0;
  logic [15:0] e_md = '0;

  initial begin
    @(posedge clk);
    live = 1'b1;
  end

  always @(negedge clk) begin
    logic nifr, nmr;
    if (live) begin
      chk("if_ready", if_ready, e_ifr);
      chk("mem_ready", mem_ready, e_mr);
      chk("if_rdata", if_rdata, e_ifd);
      chk("mem_rdata", mem_rdata, e_md);
      chk("if_stall", if_stall, if_req & ~e_ifr);
      chk("en_n", ram_en_n, (ph != 0) ? 1'b0 : 1'b1);
      chk("oe_n", ram_oe_n, (ph != 0 && !mwr) ? 1'b0 : 1'b1);
      chk("we_n", ram_we_n, (ph == 2 && mwr) ? 1'b0 : 1'b1);
      chk("data_oe", ram_data_oe, (ph != 0 && mwr));
      if (ph != 0) begin
        chk("ram_addr", ram_addr, {2'b00, maddr});
      end
      if (ph != 0 && mwr) begin
        chk("ram_dout", ram_dout, mwd);
      end
      nifr = 1'b0;
      nmr  = 1'b0;
      // The write pulse has fully happened once its cycle ends.
      if (ph == 2 && mwr) begin
        refm[maddr] = mwd;
      end
      if (!rst) begin
        ph    = 0;
        e_ifd = '0;
        e_md  = '0;
      end else if (ph != 0) begin
        if (ph == len) begin
          if (mwr) begin
            nmr = 1'b1;
          end else if (mport) begin
            e_md = refm[maddr];
            nmr  = 1'b1;
          end else begin
            e_ifd = refm[maddr];
            nifr  = 1'b1;
          end
          ph = 0;
        end else begin
          ph++;
        end
      end else if ((mem_read || mem_write) && !e_mr) begin
        mport = 1'b1;
        mwr   = mem_write;
        len   = mem_write ? 3 : 1;
        maddr = mem_addr;
        mwd   = mem_wdata;
        ph    = 1;
      end else if (if_req && !e_ifr) begin
        mport = 1'b0;
        mwr   = 1'b0;
        len   = 1;
        maddr = if_addr;
        ph    = 1;
      end
      e_ifr = nifr;
      e_mr  = nmr;
    end
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if_req    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < n; i++) next();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 16'(i) ^ 16'h5A5A;
      refm[i] = 16'(i) ^ 16'h5A5A;
    end
    sram[16] = 16'h4A21;
    refm[16] = 16'h4A21;
    if_req  = 1'b1;
    if_addr = 16'h0010;

    // reset held with a pending fetch
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rst en_n", ram_en_n, 1'b1);
      chk("rst oe_n", ram_oe_n, 1'b1);
      chk("rst we_n", ram_we_n, 1'b1);
      chk("rst data_oe", ram_data_oe, 1'b0);
      chk("rst if_ready", if_ready, 1'b0);
      chk("rst mem_ready", mem_ready, 1'b0);
      chk("rst if_stall", if_stall, 1'b1);
      chk("rst ram_addr", ram_addr, 18'h0);
    end
    next();
    rst = 1'b1;

    // fetch of 0x0010
    for (int k = 0; k <= 2; k++) begin
      smp();
      if (k == 1) begin
        chk("fetch ram_addr", ram_addr, 18'h00010);
        chk("fetch oe_n", ram_oe_n, 1'b0);
      end
      chk("fetch if_ready", if_ready, (k == 2));
      if (k == 2) begin
        chk("fetch if_rdata", if_rdata, 16'h4A21);
      end
      next();
    end
    idle(2);

    // store 0xBEEF to 0x8000
    mem_write = 1'b1;
    mem_addr  = 16'h8000;
    mem_wdata = 16'hBEEF;
    for (int k = 0; k <= 4; k++) begin
      smp();
      chk("store we_n", ram_we_n, (k != 2));
      chk("store data_oe", ram_data_oe, (k >= 1 && k <= 3));
      chk("store mem_ready", mem_ready, (k == 4));
      if (k == 1) chk("store ram_addr", ram_addr, 18'h08000);
      next();
    end
    idle(2);
    chk("store sram", sram[16'h8000], 16'hBEEF);

    // fetch and load raised together
    if_req   = 1'b1;
    if_addr  = 16'h0011;
    mem_read = 1'b1;
    mem_addr = 16'h0012;
    for (int k = 0; k <= 4; k++) begin
      smp();
      chk("conf mem_ready", mem_ready, (k == 2));
      chk("conf if_ready", if_ready, (k == 4));
      chk("conf if_stall", if_stall, (k <= 3));
      if (k == 2) chk("conf mem_rdata", mem_rdata, 16'h5A48);
      if (k == 4) chk("conf if_rdata", if_rdata, 16'h5A4B);
      next();
      if (k == 2) mem_read = 1'b0;
    end
    idle(2);

    // read and write strobes together: write wins
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 16'h0100;
    mem_wdata = 16'h1234;
    for (int k = 0; k <= 4; k++) begin
      smp();
      chk("both oe_n", ram_oe_n, 1'b1);
      chk("both we_n", ram_we_n, (k != 2));
      chk("both mem_ready", mem_ready, (k == 4));
      next();
    end
    idle(2);
    chk("both sram", sram[16'h0100], 16'h1234);

    // reset lands during the write pulse
    mem_write = 1'b1;
    mem_addr  = 16'h7777;
    mem_wdata = 16'hCAFE;
    smp();
    next();
    smp();
    next();
    rst       = 1'b0;
    mem_write = 1'b0;
    smp();
    chk("wr2 we_n", ram_we_n, 1'b0);
    next();
    rst = 1'b1;
    smp();
    chk("wrrst we_n", ram_we_n, 1'b1);
    chk("wrrst data_oe", ram_data_oe, 1'b0);
    chk("wrrst en_n", ram_en_n, 1'b1);
    chk("wrrst mem_ready", mem_ready, 1'b0);
    next();
    smp();
    chk("wrrst mem_ready2", mem_ready, 1'b0);
    next();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(149) != 0);
      if_req    = ($urandom_range(2) != 0);
      if_addr   = 16'h0020 + 16'($urandom_range(15));
      mem_read  = ($urandom_range(3) == 0);
      mem_write = ($urandom_range(4) == 0);
      mem_addr  = 16'h0020 + 16'($urandom_range(15));
      mem_wdata = 16'($urandom);
      next();
    end
    rst = 1'b1;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
